// File: rtl/alu_shift_register_if.sv
// Data and command bundle for the ALU shift register.
// The master drives the load data and commands; the slave (the register) returns its contents and carry.
interface alu_shift_register_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] IN;
    logic             LOAD_ENABLE;
    logic [1:0]       SHIFT_CTRL;
    logic [WIDTH-1:0] OUT;
    logic             FLAG;

    modport master (
        output IN,
        output LOAD_ENABLE,
        output SHIFT_CTRL,
        input  OUT,
        input  FLAG
    );

    modport slave (
        input  IN,
        input  LOAD_ENABLE,
        input  SHIFT_CTRL,
        output OUT,
        output FLAG
    );
endinterface

// File: rtl/alu_shift_register.sv
// Parallel-load logical shift register for the ALU datapath.
// The bit shifted out on each shift is kept in a registered carry flag.
module alu_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    alu_shift_register_if.slave  bus
);
    localparam logic [1:0] SHIFT_LEFT  = 2'b10;
    localparam logic [1:0] SHIFT_RIGHT = 2'b01;

    logic [WIDTH-1:0] data_reg;
    logic             flag_reg;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;

    // Zero-filled shifted copies of the register, one bit at a time.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign shl_next[gi] = 1'b0;
        end else begin : g_upper
            assign shl_next[gi] = data_reg[gi-1];
        end
        if (gi == WIDTH - 1) begin : g_msb
            assign shr_next[gi] = 1'b0;
        end else begin : g_lower
            assign shr_next[gi] = data_reg[gi+1];
        end
    end

    // Reset beats load, load beats shift; both-or-neither shift bits hold.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_reg <= '0;
            flag_reg <= 1'b0;
        end else if (bus.LOAD_ENABLE) begin
            data_reg <= bus.IN;
            flag_reg <= 1'b0;
        end else begin
            case (bus.SHIFT_CTRL)
                SHIFT_LEFT: begin
                    data_reg <= shl_next;
                    flag_reg <= data_reg[WIDTH-1];
                end
                SHIFT_RIGHT: begin
                    data_reg <= shr_next;
                    flag_reg <= data_reg[0];
                end
                default: begin
                    data_reg <= data_reg;
                    flag_reg <= flag_reg;
                end
            endcase
        end
    end

    assign bus.OUT  = data_reg;
    assign bus.FLAG = flag_reg;
endmodule

// File: tb/tb_alu_shift_register.sv
// Scoreboard bench for alu_shift_register: stimulus queues expected OUT/FLAG per clock,
// an independent monitor pops and compares one entry after every rising edge.
module tb_alu_shift_register;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             flag;
        string            name;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    alu_shift_register_if #(.WIDTH(WIDTH)) bus_if ();

    alu_shift_register #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one clock's worth of inputs at the falling edge and queue the result due after the next rise.
    task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] din,
                        input logic [1:0] sh, input logic [WIDTH-1:0] eo, input logic ef,
                        input string nm);
        exp_t e;
        logic [WIDTH-1:0] out_before;
        logic             flag_before;
        @(negedge clk);
        out_before  = bus_if.OUT;
        flag_before = bus_if.FLAG;
        rst               = r;
        bus_if.LOAD_ENABLE = ld;
        bus_if.IN          = din;
        bus_if.SHIFT_CTRL  = sh;
        #1;
        if (!$isunknown(out_before)) begin
            total++;
            if (bus_if.OUT !== out_before || bus_if.FLAG !== flag_before) begin
                bad++;
                $display("FAIL comb_path_%s: out=%b flag=%b before edge, required out=%b flag=%b",
                         nm, bus_if.OUT, bus_if.FLAG, out_before, flag_before);
            end
        end
        e.out  = eo;
        e.flag = ef;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus_if.OUT !== e.out || bus_if.FLAG !== e.flag) begin
                    bad++;
                    $display("FAIL %s: got out=%b flag=%b, required out=%b flag=%b",
                             e.name, bus_if.OUT, bus_if.FLAG, e.out, e.flag);
                end else begin
                    $display("ok   %s: out=%b flag=%b", e.name, bus_if.OUT, bus_if.FLAG);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] v;
        logic [WIDTH:0]   wide;
        int               wait_cycles;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus_if.IN          = '0;
        bus_if.LOAD_ENABLE = 1'b0;
        bus_if.SHIFT_CTRL  = 2'b00;

        // Reset dominates a simultaneous load.
        step(1'b1, 1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, "reset_over_load");
        step(1'b0, 1'b1, 4'b1111, 2'b00, 4'b1111, 1'b0, "load_after_reset");

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step(1'b0, 1'b1, v, 2'b00, v, 1'b0, $sformatf("load_sweep_%0d", i));
        end

        step(1'b0, 1'b1, 4'b0010, 2'b00, 4'b0010, 1'b0, "drain_load");
        step(1'b0, 1'b0, 4'b0000, 2'b01, 4'b0001, 1'b0, "drain_rsh1");
        step(1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 1'b1, "drain_rsh2");
        step(1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 1'b0, "drain_rsh3");

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            wide = {1'b0, v} << 1;
            step(1'b0, 1'b1, v, 2'b00, v, 1'b0, $sformatf("lsh_load_%0d", i));
            step(1'b0, 1'b0, 4'b0000, 2'b10, wide[WIDTH-1:0], wide[WIDTH],
                 $sformatf("lsh_%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step(1'b0, 1'b1, v, 2'b00, v, 1'b0, $sformatf("rsh_load_%0d", i));
            step(1'b0, 1'b0, 4'b0000, 2'b01, v >> 1, v[0], $sformatf("rsh_%0d", i));
        end

        step(1'b0, 1'b1, 4'b1100, 2'b10, 4'b1100, 1'b0, "load_beats_lsh");
        step(1'b0, 1'b0, 4'b0000, 2'b11, 4'b1100, 1'b0, "both_hold1");
        step(1'b0, 1'b0, 4'b0000, 2'b11, 4'b1100, 1'b0, "both_hold2");
        step(1'b0, 1'b0, 4'b0000, 2'b10, 4'b1000, 1'b1, "lsh_after_hold");
        step(1'b0, 1'b0, 4'b0000, 2'b00, 4'b1000, 1'b1, "flag_held");
        step(1'b0, 1'b0, 4'b0000, 2'b10, 4'b0000, 1'b1, "lsh_drain");
        step(1'b0, 1'b0, 4'b0000, 2'b10, 4'b0000, 1'b0, "lsh_zero");

        // Reset in the middle of a shift run.
        step(1'b0, 1'b1, 4'b1011, 2'b00, 4'b1011, 1'b0, "mid_load");
        step(1'b0, 1'b0, 4'b0000, 2'b01, 4'b0101, 1'b1, "mid_rsh");
        step(1'b1, 1'b0, 4'b0000, 2'b01, 4'b0000, 1'b0, "mid_reset");
        step(1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, "post_reset_hold");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
